// File: rtl/cache_axi_rd_bridge.sv
// Refill read bridge: I-cache and D-cache line refills onto a single AXI4 read channel.
// Ports: clk/rst; ic_* and dc_* refill request/return; AXI AR/R master; rd_err sticky error.
module cache_axi_rd_bridge #(
    parameter int BURST_LEN = 8,
    parameter int ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ic_rd_req,
    output logic            ic_rd_rdy,
    input  logic [31:0]     ic_rd_addr,
    output logic [31:0]     ic_ret_data,
    output logic            ic_ret_valid,
    output logic            ic_ret_last,

    input  logic            dc_rd_req,
    output logic            dc_rd_rdy,
    input  logic [31:0]     dc_rd_addr,
    output logic [31:0]     dc_ret_data,
    output logic            dc_ret_valid,
    output logic            dc_ret_last,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic            rd_err
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            beat;
    logic            at_last;
    logic            in_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign at_last = (cnt_q == LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ic_rd_rdy = 1'b0;
        dc_rd_rdy = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        beat      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // D-cache wins outright; I-cache only sees rdy when D is silent.
                dc_rd_rdy = dc_rd_req;
                ic_rd_rdy = ic_rd_req & ~dc_rd_req;
                if (dc_rd_req) begin
                    owner_d = 1'b1;
                    addr_d  = {dc_rd_addr[31:5], 5'b0};
                    state_d = S_AR;
                end else if (ic_rd_req) begin
                    owner_d = 1'b0;
                    addr_d  = {ic_rd_addr[31:5], 5'b0};
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                beat   = rvalid;
                if (rvalid) begin
                    // Bad beats are still delivered; the burst ends on our own count.
                    if ((rlast != at_last) || (rresp != 2'b00) || (rid != arid)) begin
                        err_d = 1'b1;
                    end
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_r = (state_q == S_R);

    assign arid    = ID_W'(owner_q);
    assign araddr  = addr_q;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign ic_ret_valid = beat & ~owner_q;
    assign ic_ret_last  = ic_ret_valid & at_last;
    assign ic_ret_data  = (in_r && !owner_q) ? rdata : 32'h0;

    assign dc_ret_valid = beat & owner_q;
    assign dc_ret_last  = dc_ret_valid & at_last;
    assign dc_ret_data  = (in_r && owner_q) ? rdata : 32'h0;

    assign rd_err = err_q;

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// Directed bench for cache_axi_rd_bridge: arbitration, AR hold, beat forwarding,
// error flagging and mid-burst reset, with hand-computed expectations.
module tb_cache_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [31:0] ic_rd_addr, ic_ret_data;
    logic        dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0] dc_rd_addr, dc_ret_data;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        rd_err;

    int   n_chk = 0;
    int   n_pass = 0;
    logic err_exp = 1'b0;

    cache_axi_rd_bridge #(.BURST_LEN(8), .ID_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_rd_req    (ic_rd_req),
        .ic_rd_rdy    (ic_rd_rdy),
        .ic_rd_addr   (ic_rd_addr),
        .ic_ret_data  (ic_ret_data),
        .ic_ret_valid (ic_ret_valid),
        .ic_ret_last  (ic_ret_last),
        .dc_rd_req    (dc_rd_req),
        .dc_rd_rdy    (dc_rd_rdy),
        .dc_rd_addr   (dc_rd_addr),
        .dc_ret_data  (dc_ret_data),
        .dc_ret_valid (dc_ret_valid),
        .dc_ret_last  (dc_ret_last),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present a request (optionally with a simultaneous competing one) and
    // check the handshake; the request drops right after the accepting edge.
    task automatic issue_req(input bit own, input logic [31:0] a,
                             input bit both);
        @(negedge clk);
        rvalid  = 1'b0;
        rlast   = 1'b0;
        arready = 1'b0;
        if (own) begin
            dc_rd_req  = 1'b1;
            dc_rd_addr = a;
            if (both) ic_rd_req = 1'b1;
        end else begin
            ic_rd_req  = 1'b1;
            ic_rd_addr = a;
            if (both) dc_rd_req = 1'b1;
        end
        #1;
        chk("rdy_win",  own ? dc_rd_rdy : ic_rd_rdy, 1);
        chk("rdy_lose", own ? ic_rd_rdy : dc_rd_rdy, 0);
        @(posedge clk);
        #1;
        if (own) dc_rd_req = 1'b0;
        else     ic_rd_req = 1'b0;
    endtask

    task automatic ar_phase(input bit own, input logic [31:0] a, input int nwait);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            arready = 1'b0;
            #1;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold",  araddr, a);
            chk("arid_hold",    arid, 32'(own));
        end
        @(negedge clk);
        arready = 1'b1;
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr",  araddr, a);
        chk("arid",    arid, 32'(own));
        chk("arlen",   arlen, 7);
        chk("arsize",  arsize, 2);
        chk("arburst", arburst, 1);
        chk("rready_ar", rready, 0);
        chk("rdy_after", ic_rd_rdy | dc_rd_rdy, 0);
    endtask

    task automatic r_phase(input bit own, input int nb, input int gap,
                           input int bad_resp, input int last_at);
        int pulses;
        pulses = 0;
        for (int k = 1; k <= nb; k++) begin
            if (k > 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    arready = 1'b0;
                    rvalid  = 1'b0;
                    rlast   = 1'b0;
                    #1;
                    chk("gap_valid", ic_ret_valid | dc_ret_valid, 0);
                    chk("gap_rready", rready, 1);
                    chk("gap_err", rd_err, err_exp);
                end
            end
            @(negedge clk);
            arready = 1'b0;
            rvalid  = 1'b1;
            rdata   = 32'(k) * 32'h11;
            rid     = 4'(own);
            rresp   = (k == bad_resp) ? 2'b10 : 2'b00;
            rlast   = (k == last_at);
            #1;
            chk("arvalid_r", arvalid, 0);
            chk("rready", rready, 1);
            chk("own_valid", own ? dc_ret_valid : ic_ret_valid, 1);
            chk("own_data",  own ? dc_ret_data : ic_ret_data, 32'(k) * 32'h11);
            chk("own_last",  own ? dc_ret_last : ic_ret_last, 32'(k == 8));
            chk("oth_valid", own ? ic_ret_valid : dc_ret_valid, 0);
            chk("oth_data",  own ? ic_ret_data : dc_ret_data, 0);
            chk("rdy_busy",  ic_rd_rdy | dc_rd_rdy, 0);
            chk("beat_err",  rd_err, err_exp);
            if (own ? dc_ret_valid : ic_ret_valid) pulses++;
            if (k == bad_resp || ((k == last_at) != (k == 8))) err_exp = 1'b1;
        end
        chk("pulses", pulses, nb);
    endtask

    task automatic idle_chk();
        @(negedge clk);
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        #1;
        chk("idle_rready",  rready, 0);
        chk("idle_arvalid", arvalid, 0);
        chk("idle_valid",   ic_ret_valid | dc_ret_valid, 0);
        chk("idle_data",    ic_ret_data | dc_ret_data, 0);
        chk("idle_err",     rd_err, err_exp);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"},  rready, 0);
        chk({tag, "_rdy"},     ic_rd_rdy | dc_rd_rdy, 0);
        chk({tag, "_valid"},   ic_ret_valid | dc_ret_valid, 0);
        chk({tag, "_last"},    ic_ret_last | dc_ret_last, 0);
        chk({tag, "_err"},     rd_err, 0);
        chk({tag, "_araddr"},  araddr, 0);
    endtask

    initial begin
        ic_rd_req = 1'b0; ic_rd_addr = '0;
        dc_rd_req = 1'b0; dc_rd_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0;
        rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        #1 rst = 1'b1;
        #2;
        reset_chk("rst0");
        @(negedge clk);
        rst = 1'b0;

        // I-cache alone
        issue_req(1'b0, 32'h1C00_0A34, 1'b0);
        ar_phase(1'b0, 32'h1C00_0A20, 0);
        r_phase(1'b0, 8, 0, 0, 8);
        idle_chk();

        // Both request together: D first, I accepted right after D's last beat
        ic_rd_addr = 32'h0000_2044;
        issue_req(1'b1, 32'h8000_1004, 1'b1);
        ar_phase(1'b1, 32'h8000_1000, 0);
        r_phase(1'b1, 8, 0, 0, 8);
        issue_req(1'b0, 32'h0000_2044, 1'b0);
        ar_phase(1'b0, 32'h0000_2040, 0);
        r_phase(1'b0, 8, 0, 0, 8);
        idle_chk();

        // AR back-pressure and gapped R beats
        issue_req(1'b1, 32'h4000_007C, 1'b0);
        ar_phase(1'b1, 32'h4000_0060, 5);
        r_phase(1'b1, 8, 2, 0, 8);
        idle_chk();

        // Bad response on beat 3
        issue_req(1'b0, 32'h1234_5678, 1'b0);
        ar_phase(1'b0, 32'h1234_5660, 0);
        r_phase(1'b0, 8, 0, 3, 8);
        idle_chk();
        chk("err_sticky", rd_err, 1);

        // Reset after beat 4
        issue_req(1'b0, 32'h0BAD_F00D, 1'b0);
        ar_phase(1'b0, 32'h0BAD_F000, 0);
        r_phase(1'b0, 4, 0, 0, 8);
        @(negedge clk);
        rvalid = 1'b0;
        rst    = 1'b1;
        #1;
        reset_chk("rst_mid");
        err_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ar0", arvalid, 0);
        @(negedge clk);
        #1;
        chk("post_rst_ar1", arvalid, 0);

        // Clean burst after reset
        issue_req(1'b0, 32'h0000_0100, 1'b0);
        ar_phase(1'b0, 32'h0000_0100, 0);
        r_phase(1'b0, 8, 0, 0, 8);
        idle_chk();

        // Early rlast on beat 6
        issue_req(1'b1, 32'h2000_0040, 1'b0);
        ar_phase(1'b1, 32'h2000_0040, 0);
        r_phase(1'b1, 8, 0, 0, 6);
        idle_chk();
        chk("err_rlast", rd_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_axi_rd_bridge.md
Name: cache_axi_rd_bridge

Overview:
- Memory-side neighbour of the I-cache and D-cache refill paths.
- Accepts line-refill read requests on each cache's rd_req/rd_rdy/rd_addr interface and arbitrates between the two caches.
- Issues one AXI4 INCR burst per accepted request.
- Returns the burst beats on the winning cache's ret_data/ret_valid/ret_last interface.
- One outstanding transaction at a time.

Parameters:
BURST_LEN, 8, beats per line refill (32-bit beats, 32-byte line); arlen = BURST_LEN-1
ID_W, 4, AXI ID width

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
ic_rd_req  input  1  I-cache refill request
ic_rd_rdy  output  1  I-cache request accepted this cycle
ic_rd_addr  input  32  I-cache refill address
ic_ret_data  output  32  refill beat to I-cache
ic_ret_valid  output  1  ic_ret_data valid
ic_ret_last  output  1  final beat of I-cache refill
dc_rd_req, dc_rd_rdy, dc_rd_addr, dc_ret_data, dc_ret_valid, dc_ret_last  same directions/widths as ic_*, for D-cache
arid  output  ID_W  0 = I-cache, 1 = D-cache
araddr  output  32  line-aligned burst address
arlen  output  8  BURST_LEN-1
arsize  output  3  3'b010
arburst  output  2  2'b01
arvalid  output  1  AR valid
arready  input  1  AR ready
rid  input  ID_W  R ID
rdata  input  32  R data
rresp  input  2  R response
rlast  input  1  R last
rvalid  input  1  R valid
rready  output  1  R ready
rd_err  output  1  sticky protocol/response error flag

Behaviour:
- Reset (async, immediate): state IDLE; arvalid=0, rready=0, ic/dc_rd_rdy=0, ic/dc_ret_valid=0, ic/dc_ret_last=0, rd_err=0, beat counter=0, owner=0, araddr=0.
- rst asserted mid-burst aborts the transaction unconditionally. After deassertion the block is in IDLE and issues no AR until a new request arrives.
- FSM states: IDLE, AR, R.
- IDLE:
  - dc_rd_req has fixed priority over ic_rd_req.
  - rd_rdy is asserted combinationally to the winner only, while in IDLE and its req=1. The loser's rdy stays 0.
  - Acceptance is req&rdy. On acceptance, latch owner and addr with [4:0] forced to 0, then go to AR.
  - No request: stay in IDLE.
- AR:
  - arvalid=1; araddr, arid, arlen, arsize and arburst are held stable until arready.
  - arvalid&arready -> R on the next cycle; arvalid drops in that same edge.
  - arready may be low indefinitely; the block holds in AR.
- R:
  - rready=1.
  - Each rvalid beat is forwarded combinationally (zero latency): owner's ret_data=rdata, ret_valid=rvalid. Non-owner ret_valid=0.
  - A beat counter (width clog2(BURST_LEN)) increments per beat.
  - ret_last = rvalid & (counter==BURST_LEN-1). It is generated by the bridge, not copied from rlast.
  - After the last beat: counter clears to 0 and the state returns to IDLE. The earliest next acceptance is the cycle after the last beat.
- Error checks, each setting rd_err=1 (sticky until reset) on a valid beat:
  - rlast mismatching counter==BURST_LEN-1
  - rresp!=0
  - rid != latched arid
  - Data is still forwarded and the burst still completes by beat count.
- ret_data of the non-owner and during idle: driven 0.
- A request dropped before acceptance is ignored; requests must hold req until rdy, as the caches do.
- Starvation of the I-cache under continuous D-cache requests is accepted by design.

Test Plan:
- I-cache only: ic_rd_req=1, ic_rd_addr=0x1C00_0A34, arready=1, 8 beats 0x11..0x88 with rvalid every cycle, rlast on beat 8 -> ic_rd_rdy pulses 1 cycle; araddr=0x1C00_0A20, arid=0, arlen=7, arsize=2, arburst=1; ic_ret_valid 8 cycles with data 0x11..0x88; ic_ret_last only with 0x88; dc_ret_valid=0 throughout; rd_err=0.
- Simultaneous ic_rd_req and dc_rd_req in IDLE -> dc served first (arid=1). ic_rd_rdy is asserted the cycle after the D-cache's 8th beat, and its burst follows.
- Back-pressure: arready low for 5 cycles, rvalid gapped (pattern 1,0,0,1,...) -> arvalid and araddr stable for all 5 cycles; exactly 8 ret_valid pulses; ret_last on the 8th.
- Error: rresp=2'b10 on beat 3, or rlast on beat 6 -> rd_err rises the cycle after that beat and stays 1; burst still ends after 8 beats.
- Reset mid-burst: assert rst after beat 4 -> all outputs return to reset values immediately. A new ic request after reset yields a clean 8-beat burst with the counter starting from 0.
